hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_pkg.sv | 26 ++
 rtl/hazard_forward_unit_if.sv | 33 +++
 rtl/hazard_forward_unit_fwd_select.sv | 22 ++
 rtl/hazard_forward_unit.sv | 111 +++++++++++
 tb/tb_hazard_forward_unit.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared processor definitions for the hazard/forwarding block: forward-select
// encodings, the pipeline tracking-slot record and the producer-match rule.
package hazard_forward_unit_pkg;

    localparam int REG_W = 3;
    localparam int CNT_W = 16;

    // Operand source selects presented to the execute-stage operand muxes
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_ALU = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } slot_t;

    // A slot produces register r only when it will really write a non-zero r
    function automatic logic slot_produces(input slot_t s, input logic [REG_W-1:0] r);
        return s.valid && s.reg_write && (s.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode-side bus of the hazard/forwarding unit: decode fields in, forward
// selects, stall and write-back control out.
interface hazard_forward_unit_if;

    logic        id_valid;
    logic [2:0]  RA;
    logic [2:0]  RB;
    logic        use_a;
    logic        use_b;
    logic [2:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic        stall;
    logic [2:0]  wb_rd;
    logic        wb_en;
    logic [15:0] stall_count;

    // Decode stage / pipeline controller side
    modport master (
        output id_valid, RA, RB, use_a, use_b, id_rd, id_reg_write, id_mem_read, flush,
        input  ForwardA, ForwardB, stall, wb_rd, wb_en, stall_count
    );

    // Hazard unit side
    modport slave (
        input  id_valid, RA, RB, use_a, use_b, id_rd, id_reg_write, id_mem_read, flush,
        output ForwardA, ForwardB, stall, wb_rd, wb_en, stall_count
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-slot forward matcher: reports whether one tracking slot produces the
// requested source register and, if so, the select code for that slot's stage.
module fwd_select
    import hazard_forward_unit_pkg::*;
#(
    parameter logic [1:0] CODE = FWD_ALU
) (
    input  slot_t            slot,
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    output logic [1:0]       code,
    output logic             hit
);

    // Load-ness of the slot matters only to the stall logic in the parent
    logic unused_mem_read;
    assign unused_mem_read = slot.mem_read;

    assign hit  = use_src && slot_produces(slot, src);
    assign code = hit ? CODE : FWD_RF;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding unit for a 5-stage pipeline. Tracks the
// instructions in EX/MEM/WB, picks the youngest producer for each decode
// operand, stalls one cycle on load-use and counts stall cycles.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_forward_unit_if.slave  bus
);

    slot_t            ex_p0;
    slot_t            mem_p1;
    slot_t            wb_p2;
    slot_t            id_slot;
    slot_t            slot_vec [3];
    logic [1:0]       a_code   [3];
    logic [1:0]       b_code   [3];
    logic             a_hit    [3];
    logic             b_hit    [3];
    logic             use_a_q;
    logic             use_b_q;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;
    logic             unused_wb_mem_read;

    assign slot_vec[0] = ex_p0;
    assign slot_vec[1] = mem_p1;
    assign slot_vec[2] = wb_p2;

    // Operands only look for producers when decode really reads them
    assign use_a_q = bus.id_valid && bus.use_a;
    assign use_b_q = bus.id_valid && bus.use_b;

    // Stage index g maps to select code g+1 (EX->ALU, MEM->MEM, WB->WB)
    for (genvar g = 0; g < 3; g++) begin : g_slot
        fwd_select #(.CODE(2'(g + 1))) u_fwd_a (
            .slot    (slot_vec[g]),
            .src     (bus.RA),
            .use_src (use_a_q),
            .code    (a_code[g]),
            .hit     (a_hit[g])
        );
        fwd_select #(.CODE(2'(g + 1))) u_fwd_b (
            .slot    (slot_vec[g]),
            .src     (bus.RB),
            .use_src (use_b_q),
            .code    (b_code[g]),
            .hit     (b_hit[g])
        );
    end

    // Youngest producer wins: scan oldest to youngest, later hits overwrite
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        for (int i = 2; i >= 0; i--) begin
            if (a_hit[i]) fwd_a = a_code[i];
            if (b_hit[i]) fwd_b = b_code[i];
        end
    end

    // Load in EX feeding a decode operand cannot forward yet; flush overrides
    assign stall = bus.id_valid && !bus.flush && ex_p0.mem_read && (a_hit[0] || b_hit[0]);

    // Decode record entering EX, replaced by a bubble on stall or flush
    always_comb begin
        id_slot = '0;
        if (bus.id_valid && !stall && !bus.flush) begin
            id_slot.valid     = 1'b1;
            id_slot.rd        = bus.id_rd;
            id_slot.reg_write = bus.id_reg_write;
            id_slot.mem_read  = bus.id_mem_read;
        end
    end

    // ---- ID -> EX (p0) -> MEM (p1) -> WB (p2) tracking slots ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_p0  <= '0;
            mem_p1 <= '0;
            wb_p2  <= '0;
        end else begin
            ex_p0  <= id_slot;
            mem_p1 <= ex_p0;
            wb_p2  <= mem_p1;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // WB slot load-ness has no consumer once the instruction retires
    assign unused_wb_mem_read = wb_p2.mem_read;

    assign bus.ForwardA    = fwd_a;
    assign bus.ForwardB    = fwd_b;
    assign bus.stall       = stall;
    assign bus.wb_rd       = wb_p2.rd;
    assign bus.wb_en       = wb_p2.valid && wb_p2.reg_write && (wb_p2.rd != '0);
    assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed pipeline scenarios plus randomized
// decode traffic, all checked against an instruction-list reference model.
module tb_hazard_forward_unit;

    logic clk;
    logic rst_n;

    hazard_forward_unit_if hif ();

    hazard_forward_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in-flight instructions by age (0 = in EX, 1 = MEM, 2 = WB)
    typedef struct {
        bit       v;
        bit [2:0] rd;
        bit       rw;
        bit       mr;
    } m_slot_t;

    m_slot_t     m [3];
    int unsigned m_cnt;
    int          n_pass;
    int          n_total;

    logic [24:0] got;
    logic [24:0] exp_v;

    function automatic void model_reset();
        for (int a = 0; a < 3; a++) m[a] = '{1'b0, 3'd0, 1'b0, 1'b0};
        m_cnt = 0;
    endfunction

    // Age of the youngest in-flight writer of r, or -1 if none
    function automatic int producer_age(bit [2:0] r);
        if (r == 3'd0) return -1;
        for (int a = 0; a < 3; a++)
            if (m[a].v && m[a].rw && m[a].rd == r) return a;
        return -1;
    endfunction

    function automatic bit [1:0] m_fwd(bit [2:0] r, bit u);
        int a;
        if (!hif.id_valid || !u) return 2'd0;
        a = producer_age(r);
        if (a < 0) return 2'd0;
        return 2'(a + 1);
    endfunction

    function automatic bit m_stall();
        bit hz;
        if (!hif.id_valid || hif.flush) return 1'b0;
        hz = (hif.use_a && producer_age(hif.RA) == 0 && m[0].mr) ||
             (hif.use_b && producer_age(hif.RB) == 0 && m[0].mr);
        return hz;
    endfunction

    function automatic logic [24:0] exp_vec();
        bit wbe;
        wbe = m[2].v && m[2].rw && (m[2].rd != 3'd0);
        return {m_fwd(hif.RA, hif.use_a), m_fwd(hif.RB, hif.use_b), m_stall(),
                wbe, m[2].rd, 16'(m_cnt)};
    endfunction

    function automatic logic [24:0] got_vec();
        return {hif.ForwardA, hif.ForwardB, hif.stall, hif.wb_en, hif.wb_rd, hif.stall_count};
    endfunction

    task automatic drive(bit v, bit [2:0] ra, bit [2:0] rb, bit ua, bit ub,
                         bit [2:0] rd, bit rw, bit mr, bit fl);
        hif.id_valid     = v;
        hif.RA           = ra;
        hif.RB           = rb;
        hif.use_a        = ua;
        hif.use_b        = ub;
        hif.id_rd        = rd;
        hif.id_reg_write = rw;
        hif.id_mem_read  = mr;
        hif.flush        = fl;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: advance the model with the decode inputs present at the edge
    task automatic tick();
        m_slot_t n0;
        bit      st;
        st = m_stall();
        if (hif.id_valid && !hif.flush && !st)
            n0 = '{1'b1, hif.id_rd, hif.id_reg_write, hif.id_mem_read};
        else
            n0 = '{1'b0, 3'd0, 1'b0, 1'b0};
        @(posedge clk);
        m[2] = m[1];
        m[1] = m[0];
        m[0] = n0;
        if (st && m_cnt < 65535) m_cnt++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        got = got_vec();
        if (got !== 25'd0) $display("FAIL reset_outputs got=%h exp=%h", got, 25'd0);
        else n_pass++;
        n_total++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        got = got_vec();
        if (got !== 25'd0) $display("FAIL reset_release got=%h exp=%h", got, 25'd0);
        else n_pass++;
        n_total++;
        idle();
        @(negedge clk);
    endtask

    task automatic test_alu_back_to_back();
        apply_reset();
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd3, 3'd1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        #1;
        if (hif.ForwardA !== 2'd1 || hif.stall !== 1'b0)
            $display("FAIL alu_fwd got fa=%0d st=%0d exp fa=1 st=0", hif.ForwardA, hif.stall);
        else n_pass++;
        n_total++;
        got = got_vec(); exp_v = exp_vec();
        if (got !== exp_v) $display("FAIL alu_model got=%h exp=%h", got, exp_v);
        else n_pass++;
        n_total++;
        tick();
        idle();
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        #1;
        if (hif.stall !== 1'b1) $display("FAIL lu_stall got=%0d exp=1", hif.stall);
        else n_pass++;
        n_total++;
        tick();
        if (hif.stall_count !== 16'd1 || hif.ForwardB !== 2'd2 || hif.stall !== 1'b0)
            $display("FAIL lu_mem_fwd got cnt=%0d fb=%0d st=%0d exp cnt=1 fb=2 st=0",
                     hif.stall_count, hif.ForwardB, hif.stall);
        else n_pass++;
        n_total++;
        tick();
        idle();
        #1;
        if (hif.wb_en !== 1'b1 || hif.wb_rd !== 3'd2)
            $display("FAIL lu_wb got en=%0d rd=%0d exp en=1 rd=2", hif.wb_en, hif.wb_rd);
        else n_pass++;
        n_total++;
        got = got_vec(); exp_v = exp_vec();
        if (got !== exp_v) $display("FAIL lu_model got=%h exp=%h", got, exp_v);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_priority();
        apply_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd5, 3'd1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
        #1;
        if (hif.ForwardA !== 2'd1 || hif.ForwardB !== 2'd2)
            $display("FAIL prio got fa=%0d fb=%0d exp fa=1 fb=2", hif.ForwardA, hif.ForwardB);
        else n_pass++;
        n_total++;
        tick();
        idle();
    endtask

    task automatic test_r0();
        apply_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 3'd0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        #1;
        if (hif.ForwardA !== 2'd0 || hif.ForwardB !== 2'd0)
            $display("FAIL r0_fwd got fa=%0d fb=%0d exp 0", hif.ForwardA, hif.ForwardB);
        else n_pass++;
        n_total++;
        tick();
        idle();
        tick();
        #1;
        if (hif.wb_en !== 1'b0 || hif.wb_rd !== 3'd0)
            $display("FAIL r0_wb got en=%0d rd=%0d exp en=0 rd=0", hif.wb_en, hif.wb_rd);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_flush_load_use();
        apply_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0);
        tick();
        // Flushed instruction also writes R4: were it to enter EX, the next
        // reader would see ForwardA=1 instead of the MEM-stage load
        drive(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1);
        #1;
        if (hif.stall !== 1'b0) $display("FAIL flush_stall got=%0d exp=0", hif.stall);
        else n_pass++;
        n_total++;
        tick();
        drive(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        #1;
        if (hif.ForwardA !== 2'd2 || hif.stall !== 1'b0 || hif.stall_count !== 16'd0)
            $display("FAIL flush_bubble got fa=%0d st=%0d cnt=%0d exp fa=2 st=0 cnt=0",
                     hif.ForwardA, hif.stall, hif.stall_count);
        else n_pass++;
        n_total++;
        tick();
        idle();
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd4, 3'd6, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
        #1;
        if (hif.stall !== 1'b1 || hif.wb_en !== 1'b1 || hif.wb_rd !== 3'd5)
            $display("FAIL mid_pre got st=%0d en=%0d rd=%0d exp st=1 en=1 rd=5",
                     hif.stall, hif.wb_en, hif.wb_rd);
        else n_pass++;
        n_total++;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        got = got_vec();
        if (got !== 25'd0) $display("FAIL mid_async got=%h exp=%h", got, 25'd0);
        else n_pass++;
        n_total++;
        #1 rst_n = 1'b1;
        tick();
        #1;
        got = got_vec(); exp_v = exp_vec();
        if (got !== exp_v || hif.stall !== 1'b0)
            $display("FAIL mid_after got=%h exp=%h", got, exp_v);
        else n_pass++;
        n_total++;
        idle();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) != 0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            #1;
            got = got_vec(); exp_v = exp_vec();
            if (got !== exp_v) begin
                if (bad < 10) $display("FAIL rand_cycle%0d got=%h exp=%h", c, got, exp_v);
                bad++;
            end else n_pass++;
            n_total++;
            tick();
        end
        idle();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_priority();
        test_r0();
        test_flush_load_use();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
